// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Bus initiator that copies a block of 32-bit words from a
//                source byte address to a destination byte address over a
//                word-addressed memory port (combinational read, write on
//                the clock edge). Two cycles per word, ascending order.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      adr,
    output logic [31:0]      writedata,
    output logic             memwrite,
    input  logic [31:0]      readdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [31:0]      c_WORD_BYTES = 32'd4;
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [CNT_W-1:0] r_cnt;

    // Either pointer off a word boundary rejects the request.
    logic w_misaligned;
    assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);

    // Copy sequencer; all bus outputs are registered alongside the state so
    // that memwrite is high exactly while the state register holds WRITE.
    // writedata doubles as the data buffer between READ and WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            adr       <= '0;
            writedata <= '0;
            memwrite  <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    adr       <= '0;
                    writedata <= '0;
                    memwrite  <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        if (w_misaligned) begin
                            err <= 1'b1;
                        end else if (word_count == '0) begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                        end else begin
                            r_src   <= src_addr;
                            r_dst   <= dst_addr;
                            r_cnt   <= word_count;
                            adr     <= src_addr;
                            busy    <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // Capture the source word and present the destination.
                    writedata <= readdata;
                    adr       <= r_dst;
                    memwrite  <= 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_src     <= r_src + c_WORD_BYTES;
                    r_dst     <= r_dst + c_WORD_BYTES;
                    r_cnt     <= r_cnt - c_ONE;
                    memwrite  <= 1'b0;
                    writedata <= '0;
                    if (r_cnt == c_ONE) begin
                        adr     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        adr     <= r_src + c_WORD_BYTES;
                        r_state <= S_READ;
                    end
                end
                default: begin
                    // FIN: done is high this cycle; return to idle.
                    adr       <= '0;
                    writedata <= '0;
                    memwrite  <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Self-checking bench for mem_copy_engine with a word memory
//                and a behavioural copy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

    localparam int CNT_W = 16;
    localparam int MW    = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy, done, err, memwrite;
    logic [31:0]      adr, writedata, readdata;

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];

    int checks = 0;
    int errors = 0;
    int n_wr, n_done, n_err, n_busy, n_clash;
    logic [31:0] wr_adr_q[$];

    mem_copy_engine #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .busy(busy), .done(done), .err(err),
        .adr(adr), .writedata(writedata), .memwrite(memwrite),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on rising edge (4 KB alias window).
    assign readdata = mem[adr[11:2]];
    always @(posedge clk) if (memwrite) mem[adr[11:2]] <= writedata;

    // Observation on the falling edge.
    always @(negedge clk) begin
        if (memwrite) begin
            n_wr++;
            wr_adr_q.push_back(adr);
        end
        if (done) n_done++;
        if (err) n_err++;
        if (busy) n_busy++;
        if (done && err) n_clash++;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_mon();
        n_wr = 0; n_done = 0; n_err = 0; n_busy = 0; n_clash = 0;
        wr_adr_q.delete();
    endtask

    task automatic init_mem();
        for (int i = 0; i < MW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
    endtask

    // Reference: sequential ascending word copy, addresses modulo 2^32.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da;
        for (int i = 0; i < n; i++) begin
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            ref_mem[da[11:2]] = ref_mem[sa[11:2]];
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s memory: %0d words differ, expected 0", name, bad);
        end
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n);
        clear_mon();
        start      = 1'b1;
        src_addr   = s;
        dst_addr   = d;
        word_count = CNT_W'(n);
    endtask

    task automatic run_and_check(input string name, input logic [31:0] s,
                                 input logic [31:0] d, input int n);
        int cyc, exp_cyc;
        bit seen;
        logic [31:0] ea;
        model_copy(s, d, n);
        launch(s, d, n);
        exp_cyc = (n == 0) ? 1 : 2 * n + 1;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 4 * n + 10) begin
            tick();
            cyc++;
            start = 1'b0;
            if (done) seen = 1;
        end
        tick();
        tick();
        checks++;
        if (!seen || cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d (seen=%0b), expected %0d", name, cyc, seen, exp_cyc);
        end
        checks++;
        if (n_wr != n) begin
            errors++;
            $display("FAIL %s writes: got %0d, expected %0d", name, n_wr, n);
        end
        checks++;
        if (n_done != 1 || n_err != 0 || n_clash != 0) begin
            errors++;
            $display("FAIL %s pulses: done=%0d err=%0d, expected 1 and 0", name, n_done, n_err);
        end
        checks++;
        if (n_busy != 2 * n) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, n_busy, 2 * n);
        end
        for (int i = 0; i < n && i < wr_adr_q.size(); i++) begin
            ea = d + 32'(4 * i);
            checks++;
            if (wr_adr_q[i] !== ea) begin
                errors++;
                $display("FAIL %s write adr %0d: got %h, expected %h", name, i, wr_adr_q[i], ea);
            end
        end
        check_mem(name);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
        init_mem();
        tick();
        tick();
        checks++;
        if ({busy, done, err, memwrite} !== 4'b0 || adr !== 32'h0 || writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b done=%b err=%b mw=%b adr=%h wd=%h, expected all 0",
                     busy, done, err, memwrite, adr, writedata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        init_mem();
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];
        run_and_check("basic", 32'h0, 32'h40, 4);
        checks++;
        if (mem[16] !== 32'h11111111 || mem[19] !== 32'h44444444) begin
            errors++;
            $display("FAIL basic dest: w16=%h w19=%h, expected 11111111 44444444", mem[16], mem[19]);
        end
    endtask

    task automatic test_zero();
        init_mem();
        run_and_check("zero", 32'h10, 32'h20, 0);
    endtask

    task automatic test_misalign(input logic [31:0] s, input logic [31:0] d);
        launch(s, d, 3);
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL misalign err: got %b, expected 1", err);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (n_err != 1 || n_done != 0 || n_wr != 0 || n_busy != 0) begin
            errors++;
            $display("FAIL misalign pulses: err=%0d done=%0d wr=%0d busy=%0d, expected 1 0 0 0",
                     n_err, n_done, n_wr, n_busy);
        end
        check_mem("misalign");
        run_and_check("after_misalign", 32'h80, 32'hC0, 3);
    endtask

    task automatic test_overlap();
        logic [31:0] a;
        init_mem();
        a = mem[0];
        run_and_check("overlap", 32'h0, 32'h4, 3);
        checks++;
        if (mem[1] !== a || mem[2] !== a || mem[3] !== a) begin
            errors++;
            $display("FAIL overlap words: %h %h %h, expected %h", mem[1], mem[2], mem[3], a);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            init_mem();
            run_and_check("random", 32'($urandom_range(0, 255)) << 2,
                          32'($urandom_range(0, 255)) << 2, int'($urandom_range(1, 8)));
        end
        init_mem();
        run_and_check("same", 32'h100, 32'h100, 3);
        init_mem();
        run_and_check("wrap_src", 32'hFFFFFFF8, 32'h200, 4);
        init_mem();
        run_and_check("wrap_dst", 32'h300, 32'hFFFFFFF4, 5);
    endtask

    task automatic test_reset_mid();
        int guard;
        init_mem();
        model_copy(32'h0, 32'h100, 2);
        launch(32'h0, 32'h100, 8);
        guard = 0;
        while (n_wr < 3 && guard < 20) begin
            tick();
            start = 1'b0;
            guard++;
        end
        checks++;
        if (n_wr != 3 || memwrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid reach: writes=%0d mw=%b, expected 3 and 1", n_wr, memwrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, memwrite} !== 4'b0 || adr !== 32'h0 || writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid outputs: busy=%b done=%b err=%b mw=%b adr=%h wd=%h, expected all 0",
                     busy, done, err, memwrite, adr, writedata);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (n_done != 0 || n_wr != 3) begin
            errors++;
            $display("FAIL reset_mid after: done=%0d writes=%0d, expected 0 and 3", n_done, n_wr);
        end
        check_mem("reset_mid");
    endtask

    task automatic test_start_busy();
        int cyc;
        bit seen;
        init_mem();
        model_copy(32'h40, 32'h80, 2);
        launch(32'h40, 32'h80, 2);
        tick(); start = 1'b0;              // cycle 1
        tick();                            // cycle 2
        tick();                            // cycle 3: second request
        start = 1'b1; src_addr = 32'h200; dst_addr = 32'h300; word_count = CNT_W'(5);
        cyc = 3;
        seen = 0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            start = 1'b0;
            if (done) seen = 1;
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (!seen || cyc != 5 || n_done != 1 || n_wr != 2) begin
            errors++;
            $display("FAIL start_busy: done cycle %0d seen=%0b dones=%0d writes=%0d, expected 5 1 1 2",
                     cyc, seen, n_done, n_wr);
        end
        check_mem("start_busy");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_misalign(32'h2, 32'h40);
        test_misalign(32'h0, 32'h41);
        test_overlap();
        test_random();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
